// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and decode helper for the EX-stage forwarding / load-use hazard unit.
package fwd_pkg;

   localparam int unsigned DEF_NUM_SRC = 2;
   localparam int unsigned DEF_NUM_RS  = 2;
   localparam int unsigned SEL_W       = $clog2(DEF_NUM_SRC + 1);

   // Bypass select for the default configuration: 0 = ID/EX value, k+1 = stage k
   typedef logic [SEL_W-1:0] fwd_sel_t;

   typedef enum logic [1:0] {
      HZ_IDLE    = 2'd0,
      HZ_LU_WAIT = 2'd1,
      HZ_FROZEN  = 2'd2
   } hz_state_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Operand usage mask for an rv32i opcode: bit0 = rs1, bit1 = rs2
   function automatic logic [DEF_NUM_RS-1:0] rs_used_f(input logic [6:0] opcode);
      logic [DEF_NUM_RS-1:0] m;
      case (opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM: m = 2'b00;
         OPC_JALR, OPC_LOAD, OPC_OP_IMM:          m = 2'b01;
         default:                                 m = 2'b11;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side signal bundle of the forwarding / hazard unit.
interface fwd_hazard_unit_if #(
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned NUM_RS  = 2,
   parameter int unsigned CNT_W   = 32
);
   localparam int unsigned SEL_BITS = $clog2(NUM_SRC + 1);

   logic [NUM_RS-1:0][4:0]          ex_rs;
   logic [NUM_RS-1:0]               ex_rs_used;
   logic [NUM_SRC-1:0]              src_wr;
   logic [NUM_SRC-1:0][4:0]         src_rd;
   logic [NUM_SRC-1:0]              src_is_load;
   logic                            mem_stall;
   logic                            flush;
   logic [NUM_RS-1:0][SEL_BITS-1:0] fwd_sel;
   logic                            stall;
   logic                            bubble;
   logic [CNT_W-1:0]                stall_cycles;

   modport master (
      output ex_rs, ex_rs_used, src_wr, src_rd, src_is_load, mem_stall, flush,
      input  fwd_sel, stall, bubble, stall_cycles
   );

   modport slave (
      input  ex_rs, ex_rs_used, src_wr, src_rd, src_is_load, mem_stall, flush,
      output fwd_sel, stall, bubble, stall_cycles
   );
endinterface

// File: rtl/fwd_hazard_unit_prio_sel.sv
// Per-operand youngest-wins bypass priority encoder.
module fwd_prio_sel #(
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned SEL_W   = 2
) (
   input  logic [4:0]               rs,
   input  logic                     rs_used,
   input  logic [NUM_SRC-1:0]       src_wr,
   input  logic [NUM_SRC-1:0][4:0]  src_rd,
   input  logic [NUM_SRC-1:0]       src_is_load,
   output logic [SEL_W-1:0]         sel,
   output logic                     is_load
);

   // Lowest matching stage wins; x0 never matches
   always_comb begin
      logic found;
      sel     = '0;
      is_load = 1'b0;
      found   = 1'b0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (!found && rs_used && src_wr[k] && (src_rd[k] != '0) && (src_rd[k] == rs)) begin
            found   = 1'b1;
            sel     = SEL_W'(k + 1);
            is_load = src_is_load[k];
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding select, load-use hazard sequencer and stall-cycle counter.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int unsigned NUM_SRC  = DEF_NUM_SRC,
   parameter int unsigned NUM_RS   = DEF_NUM_RS,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 32
) (
   input  logic               clk,
   input  logic               rst,
   fwd_hazard_unit_if.slave   bus
);

   localparam int unsigned SEL_BITS = $clog2(NUM_SRC + 1);
   localparam logic [2:0]  CNT_INIT = 3'(LOAD_LAT - 1);

   logic [NUM_RS-1:0][SEL_BITS-1:0] sel;
   logic [NUM_RS-1:0]               rs_load;
   logic                            hz;
   logic                            stall;

   hz_state_e        state_q, state_d;
   hz_state_e        ret_q, ret_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   for (genvar r = 0; r < NUM_RS; r++) begin : g_rs
      fwd_prio_sel #(
         .NUM_SRC (NUM_SRC),
         .SEL_W   (SEL_BITS)
      ) u_prio_sel (
         .rs          (bus.ex_rs[r]),
         .rs_used     (bus.ex_rs_used[r]),
         .src_wr      (bus.src_wr),
         .src_rd      (bus.src_rd),
         .src_is_load (bus.src_is_load),
         .sel         (sel[r]),
         .is_load     (rs_load[r])
      );
   end

   assign hz = |rs_load;

   // Stall/bubble: hold the front end on hazard or pending latency; freeze and flush override
   always_comb begin
      stall = (hz || (state_q == HZ_LU_WAIT)) && !bus.flush && !bus.mem_stall;
   end

   assign bus.fwd_sel      = sel;
   assign bus.stall        = stall;
   assign bus.bubble       = stall && !bus.mem_stall;
   assign bus.stall_cycles = stall_cycles_q;

   // Sequencer next state; the freeze-release cycle from IDLE re-evaluates the hazard
   // so a load-use seen in that cycle still starts its latency wait
   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      cnt_d   = cnt_q;
      if (bus.flush) begin
         state_d = HZ_IDLE;
         ret_d   = HZ_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            HZ_IDLE: begin
               if (bus.mem_stall) begin
                  state_d = HZ_FROZEN;
                  ret_d   = HZ_IDLE;
               end else if (hz && (LOAD_LAT > 1)) begin
                  state_d = HZ_LU_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
            HZ_LU_WAIT: begin
               if (bus.mem_stall) begin
                  state_d = HZ_FROZEN;
                  ret_d   = HZ_LU_WAIT;
               end else begin
                  cnt_d = (cnt_q != '0) ? cnt_q - 3'd1 : '0;
                  if ((cnt_d == '0) && !hz) begin
                     state_d = HZ_IDLE;
                  end
               end
            end
            HZ_FROZEN: begin
               if (!bus.mem_stall) begin
                  if (ret_q == HZ_LU_WAIT) begin
                     state_d = HZ_LU_WAIT;
                  end else if (hz && (LOAD_LAT > 1)) begin
                     state_d = HZ_LU_WAIT;
                     cnt_d   = CNT_INIT;
                  end else begin
                     state_d = HZ_IDLE;
                  end
               end
            end
            default: begin
               state_d = HZ_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Saturating stall-cycle counter
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && !(&stall_cycles_q)) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= HZ_IDLE;
         ret_q          <= HZ_IDLE;
         cnt_q          <= '0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         ret_q          <= ret_d;
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: three configurations (LOAD_LAT=1, LOAD_LAT=3, CNT_W=4).
module tb_fwd_hazard_unit;

   logic clk = 1'b0;
   logic rst_a, rst_b, rst_c;
   int unsigned cyc = 0;
   int compared = 0;
   int mismatched = 0;

   typedef struct {
      int unsigned cyc;
      int          dut;
      string       nm;
      logic [1:0]  s0;
      logic [1:0]  s1;
      logic        st;
      logic        bb;
      logic [31:0] sc;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fwd_hazard_unit_if #(.NUM_SRC(2), .NUM_RS(2), .CNT_W(32)) ia ();
   fwd_hazard_unit_if #(.NUM_SRC(2), .NUM_RS(2), .CNT_W(32)) ib ();
   fwd_hazard_unit_if #(.NUM_SRC(2), .NUM_RS(2), .CNT_W(4))  ic ();

   fwd_hazard_unit #(.NUM_SRC(2), .NUM_RS(2), .LOAD_LAT(1), .CNT_W(32)) dut_a (
      .clk (clk), .rst (rst_a), .bus (ia));
   fwd_hazard_unit #(.NUM_SRC(2), .NUM_RS(2), .LOAD_LAT(3), .CNT_W(32)) dut_b (
      .clk (clk), .rst (rst_b), .bus (ib));
   fwd_hazard_unit #(.NUM_SRC(2), .NUM_RS(2), .LOAD_LAT(1), .CNT_W(4)) dut_c (
      .clk (clk), .rst (rst_c), .bus (ic));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int d, input logic [4:0] rs0, input logic [4:0] rs1,
                      input logic [1:0] used, input logic [1:0] wr,
                      input logic [4:0] rd0, input logic [4:0] rd1,
                      input logic [1:0] ld, input logic ms, input logic fl);
      case (d)
         0: begin
            ia.ex_rs = {rs1, rs0}; ia.ex_rs_used = used; ia.src_wr = wr;
            ia.src_rd = {rd1, rd0}; ia.src_is_load = ld; ia.mem_stall = ms; ia.flush = fl;
         end
         1: begin
            ib.ex_rs = {rs1, rs0}; ib.ex_rs_used = used; ib.src_wr = wr;
            ib.src_rd = {rd1, rd0}; ib.src_is_load = ld; ib.mem_stall = ms; ib.flush = fl;
         end
         default: begin
            ic.ex_rs = {rs1, rs0}; ic.ex_rs_used = used; ic.src_wr = wr;
            ic.src_rd = {rd1, rd0}; ic.src_is_load = ld; ic.mem_stall = ms; ic.flush = fl;
         end
      endcase
   endtask

   task automatic idle(input int d);
      drv(d, 5'd0, 5'd0, 2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
   endtask

   task automatic expect_out(input int d, input string nm, input logic [1:0] s0,
                             input logic [1:0] s1, input logic st, input logic bb,
                             input logic [31:0] sc);
      exp_t e;
      e.cyc = cyc; e.dut = d; e.nm = nm;
      e.s0 = s0; e.s1 = s1; e.st = st; e.bb = bb; e.sc = sc;
      sb.push_back(e);
   endtask

   // Monitor: compare every expectation due in the current cycle, away from the clock edge
   exp_t        me;
   logic [1:0]  a0, a1;
   logic        ast, abb;
   logic [31:0] asc;

   always @(negedge clk) begin
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
         me = sb.pop_front();
         case (me.dut)
            0: begin
               a0 = ia.fwd_sel[0]; a1 = ia.fwd_sel[1];
               ast = ia.stall; abb = ia.bubble; asc = ia.stall_cycles;
            end
            1: begin
               a0 = ib.fwd_sel[0]; a1 = ib.fwd_sel[1];
               ast = ib.stall; abb = ib.bubble; asc = ib.stall_cycles;
            end
            default: begin
               a0 = ic.fwd_sel[0]; a1 = ic.fwd_sel[1];
               ast = ic.stall; abb = ic.bubble; asc = 32'(ic.stall_cycles);
            end
         endcase
         compared++;
         if (me.cyc != cyc || {a0, a1, ast, abb, asc} !== {me.s0, me.s1, me.st, me.bb, me.sc}) begin
            mismatched++;
            $display("FAIL %s (dut %0d cyc %0d): got sel=%0d/%0d stall=%b bubble=%b cnt=%0d, want sel=%0d/%0d stall=%b bubble=%b cnt=%0d",
                     me.nm, me.dut, cyc, a0, a1, ast, abb, asc,
                     me.s0, me.s1, me.st, me.bb, me.sc);
         end
      end
   end

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      idle(0); idle(1); idle(2);

      // Reset state, then idle after release
      tick();
      expect_out(0, "reset_a", 2'd0, 2'd0, 1'b0, 1'b0, 32'd0);
      expect_out(1, "reset_b", 2'd0, 2'd0, 1'b0, 1'b0, 32'd0);
      expect_out(2, "reset_c", 2'd0, 2'd0, 1'b0, 1'b0, 32'd0);
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      tick();
      expect_out(0, "idle_a", 2'd0, 2'd0, 1'b0, 1'b0, 32'd0);
      expect_out(1, "idle_b", 2'd0, 2'd0, 1'b0, 1'b0, 32'd0);

      // ---- DUT a: LOAD_LAT = 1 ----
      tick(); drv(0, 5'd5, 5'd0, 2'b01, 2'b11, 5'd5, 5'd5, 2'b00, 1'b0, 1'b0);
      expect_out(0, "fwd_youngest", 2'd1, 2'd0, 1'b0, 1'b0, 32'd0);
      tick(); drv(0, 5'd7, 5'd0, 2'b11, 2'b11, 5'd0, 5'd7, 2'b00, 1'b0, 1'b0);
      expect_out(0, "fwd_x0_stage1", 2'd2, 2'd0, 1'b0, 1'b0, 32'd0);
      tick(); drv(0, 5'd9, 5'd9, 2'b00, 2'b11, 5'd9, 5'd9, 2'b00, 1'b0, 1'b0);
      expect_out(0, "fwd_unused", 2'd0, 2'd0, 1'b0, 1'b0, 32'd0);
      tick(); drv(0, 5'd3, 5'd0, 2'b01, 2'b01, 5'd3, 5'd0, 2'b01, 1'b0, 1'b0);
      expect_out(0, "lu_lat1_stall", 2'd1, 2'd0, 1'b1, 1'b1, 32'd0);
      tick(); drv(0, 5'd3, 5'd0, 2'b01, 2'b10, 5'd0, 5'd3, 2'b00, 1'b0, 1'b0);
      expect_out(0, "lu_lat1_release", 2'd2, 2'd0, 1'b0, 1'b0, 32'd1);
      tick(); drv(0, 5'd0, 5'd4, 2'b10, 2'b11, 5'd4, 5'd4, 2'b10, 1'b0, 1'b0);
      expect_out(0, "older_load_masked", 2'd0, 2'd1, 1'b0, 1'b0, 32'd1);
      tick(); drv(0, 5'd0, 5'd4, 2'b10, 2'b11, 5'd4, 5'd4, 2'b01, 1'b0, 1'b0);
      expect_out(0, "younger_load", 2'd0, 2'd1, 1'b1, 1'b1, 32'd1);
      tick(); drv(0, 5'd0, 5'd4, 2'b10, 2'b11, 5'd4, 5'd4, 2'b01, 1'b0, 1'b1);
      expect_out(0, "flush_hz", 2'd0, 2'd1, 1'b0, 1'b0, 32'd2);
      tick(); idle(0);
      expect_out(0, "after_flush", 2'd0, 2'd0, 1'b0, 1'b0, 32'd2);
      tick(); drv(0, 5'd0, 5'd4, 2'b10, 2'b11, 5'd4, 5'd4, 2'b01, 1'b1, 1'b0);
      expect_out(0, "mstall_hz", 2'd0, 2'd1, 1'b0, 1'b0, 32'd2);
      tick(); drv(0, 5'd0, 5'd0, 2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
      expect_out(0, "frozen_a", 2'd0, 2'd0, 1'b0, 1'b0, 32'd2);
      tick(); idle(0);
      expect_out(0, "unfreeze_a", 2'd0, 2'd0, 1'b0, 1'b0, 32'd2);
      tick();
      expect_out(0, "idle_after_freeze", 2'd0, 2'd0, 1'b0, 1'b0, 32'd2);

      // ---- DUT b: LOAD_LAT = 3, freeze during the second stall cycle ----
      tick(); drv(1, 5'd3, 5'd0, 2'b01, 2'b01, 5'd3, 5'd0, 2'b01, 1'b0, 1'b0);
      expect_out(1, "lu3_c1", 2'd1, 2'd0, 1'b1, 1'b1, 32'd0);
      tick(); drv(1, 5'd3, 5'd0, 2'b01, 2'b10, 5'd0, 5'd3, 2'b00, 1'b1, 1'b0);
      expect_out(1, "lu3_freeze", 2'd2, 2'd0, 1'b0, 1'b0, 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out(1, "lu3_frozen", 2'd2, 2'd0, 1'b0, 1'b0, 32'd1);
      end
      tick(); drv(1, 5'd3, 5'd0, 2'b01, 2'b10, 5'd0, 5'd3, 2'b00, 1'b0, 1'b0);
      expect_out(1, "lu3_unfreeze", 2'd2, 2'd0, 1'b0, 1'b0, 32'd1);
      tick();
      expect_out(1, "lu3_c2", 2'd2, 2'd0, 1'b1, 1'b1, 32'd1);
      tick();
      expect_out(1, "lu3_c3", 2'd2, 2'd0, 1'b1, 1'b1, 32'd2);
      tick();
      expect_out(1, "lu3_done", 2'd2, 2'd0, 1'b0, 1'b0, 32'd3);

      // Flush on the first load-use cycle
      tick(); drv(1, 5'd3, 5'd0, 2'b01, 2'b01, 5'd3, 5'd0, 2'b01, 1'b0, 1'b1);
      expect_out(1, "lu3_flush", 2'd1, 2'd0, 1'b0, 1'b0, 32'd3);
      tick(); idle(1);
      expect_out(1, "flush_idle", 2'd0, 2'd0, 1'b0, 1'b0, 32'd3);

      // Asynchronous reset while in LU_WAIT
      tick(); drv(1, 5'd3, 5'd0, 2'b01, 2'b01, 5'd3, 5'd0, 2'b01, 1'b0, 1'b0);
      expect_out(1, "lu3_again", 2'd1, 2'd0, 1'b1, 1'b1, 32'd3);
      tick(); idle(1);
      expect_out(1, "lu3_wait", 2'd0, 2'd0, 1'b1, 1'b1, 32'd4);
      tick(); idle(1); rst_b = 1'b0;
      expect_out(1, "rst_in_wait", 2'd0, 2'd0, 1'b0, 1'b0, 32'd0);
      tick(); rst_b = 1'b1;
      tick();
      expect_out(1, "after_rst_b", 2'd0, 2'd0, 1'b0, 1'b0, 32'd0);

      // ---- DUT c: CNT_W = 4, 20 consecutive stall cycles ----
      for (int i = 0; i < 20; i++) begin
         tick(); drv(2, 5'd3, 5'd0, 2'b01, 2'b01, 5'd3, 5'd0, 2'b01, 1'b0, 1'b0);
         expect_out(2, "sat_run", 2'd1, 2'd0, 1'b1, 1'b1, (i < 15) ? 32'(i) : 32'd15);
      end
      tick(); idle(2);
      expect_out(2, "sat_hold", 2'd0, 2'd0, 1'b0, 1'b0, 32'd15);

      tick();
      tick();
      if (sb.size() != 0) begin
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
         compared++;
         mismatched++;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the EX stage of the pipelined rv32i core. Selects a bypass source per EX operand from any of `NUM_SRC` downstream pipeline stages with youngest-wins priority. Detects load-use (and multi-cycle load latency) hazards and runs a small stall sequencer that holds the front end and injects bubbles. Keeps a saturating stall-cycle counter for performance analysis.

## Interface
Parameters:
- `NUM_SRC`, 2: number of forwarding stages; index 0 = EX/MEM (youngest), index `NUM_SRC-1` = oldest.
- `NUM_RS`, 2: number of EX source operands.
- `LOAD_LAT`, 1: cycles after EX/MEM before load data is forwardable; range 1..7.
- `CNT_W`, 32: stall counter width.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset; asynchronous, active-low.
- `ex_rs`, in, `NUM_RS`x5: EX operand register addresses.
- `ex_rs_used`, in, `NUM_RS`: operand actually read by the EX instruction.
- `src_wr`, in, `NUM_SRC`: stage k writes the register file (`load_regfile`).
- `src_rd`, in, `NUM_SRC`x5: stage k destination.
- `src_is_load`, in, `NUM_SRC`: stage k holds a load whose data is not yet valid in that stage.
- `mem_stall`, in, 1: global pipeline freeze (cache miss).
- `flush`, in, 1: branch/jump redirect; EX contents are squashed.
- `fwd_sel`, out, `NUM_RS` x `SEL_W` (`SEL_W = $clog2(NUM_SRC+1)`): 0 = ID/EX register value, k+1 = stage k.
- `stall`, out, 1: hold PC, IF/ID, ID/EX.
- `bubble`, out, 1: load NOP into EX/MEM.
- `stall_cycles`, out, `CNT_W`: saturating count of cycles with `stall`=1.

## Operation
- Match for operand r, stage k: `ex_rs_used[r] && src_wr[k] && src_rd[k] != 0 && src_rd[k] == ex_rs[r]`.
- `fwd_sel[r]` = k+1 for the lowest matching k; 0 if there is no match. x0 is never forwarded.
- Hazard `hz`: an operand whose lowest matching stage has `src_is_load[k]`=1. An older match never masks a younger load.
- States: IDLE, LU_WAIT, FROZEN. Counter `cnt` is 3 bits.
- IDLE:
  - If `hz` and not `mem_stall`: go to LU_WAIT with `cnt` = `LOAD_LAT`-1. If `LOAD_LAT`=1, stay in IDLE; the hazard clears once the bubble advances the load.
  - If `mem_stall`: go to FROZEN.
- LU_WAIT:
  - `cnt` decrements each non-frozen cycle.
  - Return to IDLE when `cnt`=0 and not `hz`.
  - If `mem_stall`: go to FROZEN, retaining `cnt`.
- FROZEN:
  - Return to the state held before the freeze when `mem_stall` deasserts; `cnt` is unchanged.
- Outputs:
  - `stall` = (`hz` || state==LU_WAIT) && !`flush`.
  - `bubble` = `stall` && !`mem_stall`.
  - While `mem_stall`=1, `stall` and `bubble` are 0. The freeze itself holds the pipe.
- `flush` has priority over everything except reset:
  - Next state is IDLE, `cnt` is cleared.
  - `stall` and `bubble` are forced to 0 in that cycle.
  - `fwd_sel` is still computed.
- `stall_cycles` increments on every `stall`=1 cycle and saturates at all-ones.

## Timing
- `fwd_sel`, `hz`, `stall`, `bubble` are combinational from current inputs and state; zero-cycle latency.
- State, `cnt`, and `stall_cycles` update on the rising `clk` edge.
- Reset values: state IDLE, `cnt` 0, `stall_cycles` 0. With inputs idle, `fwd_sel` reads all 0 and `stall`/`bubble` read 0.
- Reset asserted mid-stall drops `stall` immediately (asynchronous reset).
- Load-use with `LOAD_LAT`=L costs exactly L stall cycles, excluding frozen cycles.
- `mem_stall` and `hz` in the same cycle: FROZEN is entered and no stall cycle is counted.
- `flush` and `hz` in the same cycle: no stall is asserted.

## Structure
- Package `fwd_pkg` holds:
  - `fwd_sel_t` (parametrised width via `SEL_W` localparam),
  - the state enum `hz_state_e`,
  - function `rs_used_f(rv32i_opcode)` returning the `NUM_RS` usage mask (lui/auipc/jal/csr → 00; jalr/load/imm → 01; others → 11). The decode stage calls it.
- One sub-module, `fwd_prio_sel`: a per-operand priority encoder over `NUM_SRC` stages returning the select and the matched stage's `is_load`. It is instantiated `NUM_RS` times.

## Test plan
- `NUM_SRC`=2, `ex_rs[0]`=5, `ex_rs_used`=01, stage0 and stage1 both write rd 5, no loads → `fwd_sel[0]`=1, `stall`=0.
- `ex_rs[1]`=0, stage0 writes rd 0 → `fwd_sel[1]`=0. Operand unused with rd match → `fwd_sel`=0.
- `LOAD_LAT`=1, stage0 load to rd 3, `ex_rs[0]`=3 → exactly 1 cycle `stall`=`bubble`=1. Next cycle the load is in stage1 (`src_is_load`=0), giving `fwd_sel[0]`=2 and `stall_cycles`=1.
- `LOAD_LAT`=3 load-use with `mem_stall`=1 for 4 cycles during the second stall cycle → 3 stall cycles total, `bubble`=0 while frozen, `stall_cycles`=3.
- Load-use with `flush`=1 on the first cycle → `stall`=0, state IDLE next cycle. `rst` asserted in LU_WAIT → `stall`=0 immediately and `stall_cycles`=0.
- `CNT_W`=4, 20 consecutive stall cycles → `stall_cycles` holds at 15.
